// File: rtl/layer_compositor.sv
// layer_compositor: two-stage pipelined layer compositor.
// Stage 1 picks the pixel (splash / priority mix / blank) and applies the
// halt dim. Stage 2 applies the fade level. The frame-synchronised fade
// FSM and the multiply exist only when LAYER_COMPOSITOR_FADE_EN is defined.
// Without it, the displayed mode follows game_state on every frame_start.
module layer_compositor #(
   parameter int NUM_LAYERS = 3,
   parameter int FADE_DIV   = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    pix_valid,
   input  logic                    frame_start,
   input  logic [3:0]              game_state,
   input  logic [15:0]             layer_splash,
   input  logic [16*NUM_LAYERS-1:0] layers,
   output logic [11:0]             data_out,
   output logic                    data_valid,
   output logic [3:0]              active_mode,
   output logic                    busy
);
   localparam logic [3:0] MODE_BEGIN  = 4'd0;
   localparam logic [3:0] MODE_INGAME = 4'd1;
   localparam logic [3:0] MODE_HALT   = 4'd2;

   logic [3:0]  mode_q;
   logic [11:0] mix, sel;
   logic [11:0] s1_pix_q;
   logic [1:0]  vld_q;
   logic [11:0] out_q;
   logic        unused_bits;

   // Channel scale: (c * level) >> 4, level 16 is the identity
   function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] l);
      logic [8:0] p;
      p = {5'd0, c} * {4'd0, l};
      return 4'(p >> 4);
   endfunction

   // Highest-index opaque layer wins; transparent everywhere gives black
   always_comb begin
      mix = 12'h000;
      unused_bits = ^layer_splash[3:0];
      for (int k = 0; k < NUM_LAYERS; k++) begin
         unused_bits = unused_bits ^ (^layers[16*k+1 +: 3]);
         if (layers[16*k]) mix = layers[16*k+4 +: 12];
      end
   end

   // Mode-dependent source selection with halt dim (uses pre-update mode)
   always_comb begin
      case (mode_q)
         MODE_BEGIN:  sel = layer_splash[15:4];
         MODE_INGAME: sel = mix;
         MODE_HALT:   sel = {1'b0, mix[11:9], 1'b0, mix[7:5], 1'b0, mix[3:1]};
         default:     sel = 12'h000;
      endcase
   end

`ifdef LAYER_COMPOSITOR_FADE_EN
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_OUT  = 2'd1;
   localparam logic [1:0] ST_IN   = 2'd2;
   localparam int CW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(FADE_DIV - 1);

   logic [1:0]    state_q, state_d;
   logic [4:0]    lvl_q, lvl_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_nx;
   logic [3:0]    mode_d;
   logic          wrap;
   logic [4:0]    s1_lvl_q;

   // Fade FSM: decisions only on frame_start; the entry pulse from IDLE
   // counts as the first step pulse so a full fade is 32*FADE_DIV pulses
   always_comb begin
      state_d = state_q;
      lvl_d   = lvl_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      wrap    = (cnt_q == CNT_MAX);
      cnt_nx  = wrap ? '0 : cnt_q + CW'(1);
      if (frame_start) begin
         case (state_q)
            ST_IDLE: if (game_state != mode_q) begin
               state_d = ST_OUT;
               cnt_d   = cnt_nx;
               if (wrap) lvl_d = lvl_q - 5'd1;
            end
            ST_OUT: if (game_state == mode_q) begin
               state_d = ST_IN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_nx;
               if (wrap) begin
                  if (lvl_q <= 5'd1) begin
                     lvl_d   = 5'd0;
                     mode_d  = game_state;
                     state_d = ST_IN;
                     cnt_d   = '0;
                  end else begin
                     lvl_d = lvl_q - 5'd1;
                  end
               end
            end
            ST_IN: if (game_state != mode_q) begin
               state_d = ST_OUT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_nx;
               if (wrap) begin
                  lvl_d = lvl_q + 5'd1;
                  if (lvl_q >= 5'd15) begin
                     state_d = ST_IDLE;
                     cnt_d   = '0;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               lvl_d   = 5'd16;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Fade state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         lvl_q   <= 5'd16;
         cnt_q   <= '0;
         mode_q  <= MODE_BEGIN;
      end else begin
         state_q <= state_d;
         lvl_q   <= lvl_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   // Level travels with the pixel through stage 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         s1_lvl_q <= 5'd16;
      else if (pix_valid) s1_lvl_q <= lvl_q;
   end

   // Stage 2: fade multiply
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       out_q <= 12'h000;
      else if (vld_q[0]) out_q <= {scale(s1_pix_q[11:8], s1_lvl_q),
                                   scale(s1_pix_q[7:4],  s1_lvl_q),
                                   scale(s1_pix_q[3:0],  s1_lvl_q)};
   end

   assign busy = (state_q != ST_IDLE);
`else
   // Mode follows the request directly at each frame boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          mode_q <= MODE_BEGIN;
      else if (frame_start) mode_q <= game_state;
   end

   // Stage 2: plain register keeps latency at two cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        out_q <= 12'h000;
      else if (vld_q[0]) out_q <= s1_pix_q;
   end

   assign busy = 1'b0;
`endif

   // Stage 1 pixel register and valid shift register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_pix_q <= 12'h000;
         vld_q    <= 2'b00;
      end else begin
         vld_q <= {vld_q[0], pix_valid};
         if (pix_valid) s1_pix_q <= sel;
      end
   end

   assign data_out    = out_q;
   assign data_valid  = vld_q[1];
   assign active_mode = mode_q;
endmodule
